// File: rtl/slave_tx_pkg.sv
// Shared types and default parameter values for the slave transmit serializer.
package slave_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LSB_FIRST  = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DATA_WIDTH-1:0]             din,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full   = (r_count == LW'(FIFO_DEPTH));
    assign empty  = (r_count == '0);
    assign level  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/slave_tx_serializer.sv
// Buffers response words and shifts them out one bit per cycle, back-to-back while
// words are queued and the master is ready at each frame start.
module slave_tx_serializer
    import slave_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LSB_FIRST  = DEF_LSB_FIRST
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              slave_valid,
    input  logic [DATA_WIDTH-1:0]             datain,
    output logic                              slave_ready,
    input  logic                              master_ready,
    output logic                              tx_data,
    output logic                              tx_valid,
    output logic                              slave_tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_start;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (slave_valid),
        .pop   (w_pop),
        .din   (datain),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign slave_ready = ~w_full;
    assign w_last      = (r_cnt == LAST_BIT);
    // master_ready only matters when a new frame would begin.
    assign w_start     = ~w_empty & master_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_pop         = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 1'b0;
        slave_tx_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                tx_valid      = 1'b1;
                tx_data       = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_WIDTH-1];
                slave_tx_done = w_last;
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (w_start) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_slave_tx_serializer.sv
// Scoreboard bench: stimulus queues expected {bit, done} pairs, monitors compare serial output.
module tb_slave_tx_serializer;

    logic       clk;
    logic       reset;
    logic       sv_a, sv_b;
    logic [7:0] din_a, din_b;
    logic       sr_a, sr_b;
    logic       mr_a, mr_b;
    logic       txd_a, txd_b;
    logic       txv_a, txv_b;
    logic       done_a, done_b;
    logic [2:0] lvl_a, lvl_b;

    int checks   = 0;
    int failures = 0;
    int done_cnt_a = 0;
    logic [1:0] q_a [$];
    logic [1:0] q_b [$];

    slave_tx_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .LSB_FIRST(1)) u_dut_a (
        .clk (clk), .reset (reset), .slave_valid (sv_a), .datain (din_a),
        .slave_ready (sr_a), .master_ready (mr_a), .tx_data (txd_a), .tx_valid (txv_a),
        .slave_tx_done (done_a), .fifo_level (lvl_a)
    );

    slave_tx_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .LSB_FIRST(0)) u_dut_b (
        .clk (clk), .reset (reset), .slave_valid (sv_b), .datain (din_b),
        .slave_ready (sr_b), .master_ready (mr_b), .tx_data (txd_b), .tx_valid (txv_b),
        .slave_tx_done (done_b), .fifo_level (lvl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Push a word into DUT A; the first nbits bits of its frame are expected on the wire.
    task automatic push_a(input logic [7:0] w, input int nbits);
        sv_a  = 1'b1;
        din_a = w;
        for (int k = 0; k < nbits; k++) q_a.push_back({w[k], (k == 7)});
        @(posedge clk);
        #1;
        sv_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] w);
        sv_b  = 1'b1;
        din_b = w;
        for (int k = 0; k < 8; k++) q_b.push_back({w[7-k], (k == 7)});
        @(posedge clk);
        #1;
        sv_b = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (txv_a) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_bit actual=tx_valid=1 required=no frame pending");
            end else begin
                e = q_a.pop_front();
                chk("a_tx_data", int'(txd_a), int'(e[1]));
                chk("a_done", int'(done_a), int'(e[0]));
            end
        end else begin
            chk("a_idle_outputs", int'({txd_a, done_a}), 0);
        end
        if (done_a) done_cnt_a++;
        if (txv_b) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_bit actual=tx_valid=1 required=no frame pending");
            end else begin
                e = q_b.pop_front();
                chk("b_tx_data", int'(txd_b), int'(e[1]));
                chk("b_done", int'(done_b), int'(e[0]));
            end
        end else begin
            chk("b_idle_outputs", int'({txd_b, done_b}), 0);
        end
    end

    initial begin
        int n, d, base;
        reset = 1'b0;
        sv_a = 1'b0; sv_b = 1'b0; din_a = '0; din_b = '0;
        mr_a = 1'b0; mr_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", int'(lvl_a), 0);
        chk("rst_ready", int'(sr_a), 1);
        chk("rst_valid", int'(txv_a), 0);
        reset = 1'b1;

        // Single frame 0xA5, minimum latency
        mr_a = 1'b1;
        push_a(8'hA5, 8);
        @(negedge clk);
        chk("lat_not_yet", int'(txv_a), 0);
        @(negedge clk);
        chk("lat_bit0", int'(txv_a), 1);
        repeat (10) @(posedge clk);
        #1;

        // MSB-first variant
        push_b(8'h01);
        repeat (12) @(posedge clk);
        #1;

        // Back-to-back frames without gap
        push_a(8'h3C, 8);
        push_a(8'hC3, 8);
        n = 0; d = 0;
        repeat (16) begin
            @(negedge clk);
            n += int'(txv_a);
            d += int'(done_a);
        end
        chk("b2b_valid_cycles", n, 16);
        chk("b2b_done_pulses", d, 2);
        @(negedge clk);
        chk("b2b_idle_after", int'(txv_a), 0);

        // Fill FIFO while master not ready; overflow word dropped
        @(posedge clk);
        #1 mr_a = 1'b0;
        push_a(8'h11, 8);
        push_a(8'h22, 8);
        push_a(8'h33, 8);
        push_a(8'h44, 8);
        @(negedge clk);
        chk("full_level", int'(lvl_a), 4);
        chk("full_ready", int'(sr_a), 0);
        push_a(8'h55, 0);
        @(negedge clk);
        chk("overflow_level", int'(lvl_a), 4);
        base = done_cnt_a;
        @(posedge clk);
        #1 mr_a = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_frames", done_cnt_a - base, 4);
        chk("drain_queue", q_a.size(), 0);

        // master_ready dropped mid-frame
        push_a(8'h0F, 8);
        push_a(8'h55, 8);
        @(posedge clk);
        @(posedge clk);
        #1 mr_a = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("hold_level", int'(lvl_a), 1);
        chk("hold_valid", int'(txv_a), 0);
        @(posedge clk);
        #1 mr_a = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("resume_level", int'(lvl_a), 0);

        // Reset during bit 3 of 0xFF with two words queued
        push_a(8'hFF, 3);
        @(posedge clk);
        #1 mr_a = 1'b0;
        push_a(8'h12, 0);
        push_a(8'h34, 0);
        @(negedge clk);
        chk("pre_rst_level", int'(lvl_a), 2);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_valid", int'(txv_a), 0);
        chk("midrst_data", int'(txd_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_level", int'(lvl_a), 0);
        chk("midrst_ready", int'(sr_a), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mr_a = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(txv_a);
        end
        chk("post_rst_silent", n, 0);

        repeat (3) @(posedge clk);
        chk("final_queue_a", q_a.size(), 0);
        chk("final_queue_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slave_tx_serializer.md
SLAVE_TX_SERIALIZER -- requirements
Module: slave_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=2).
REQ-002 Parameter FIFO_DEPTH, default 4, buffered word count (power of 2, >=2).
REQ-003 Parameter LSB_FIRST, default 1, bit order (1 = bit 0 first, 0 = bit DATA_WIDTH-1 first).
REQ-004 One clock, clk; reset is asynchronous and active-low, port reset (asserted at 0).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 slave_valid  input  1  datain holds a word to send.
REQ-008 datain  input  DATA_WIDTH  response word from the slave core.
REQ-009 slave_ready  output  1  FIFO can accept a word (not full).
REQ-010 master_ready  input  1  master can accept a new frame.
REQ-011 tx_data  output  1  serial data bit to the master.
REQ-012 tx_valid  output  1  tx_data carries a frame bit this cycle.
REQ-013 slave_tx_done  output  1  one-cycle pulse coincident with the last bit of a frame.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH+1)  words currently buffered.

Function
REQ-015 Push: word accepted at a rising edge when slave_valid=1 and slave_ready=1.
REQ-016 slave_ready is combinational: 1 when fifo_level<FIFO_DEPTH, else 0; slave_valid while full is ignored and the word is not stored.
REQ-017 FSM states: IDLE, SHIFT.
REQ-018 IDLE->SHIFT at an edge where fifo_level>0 and master_ready=1: pop head word into the shift register and clear the bit counter.
REQ-019 Cycle k after that load edge (k=0..DATA_WIDTH-1): tx_valid=1, tx_data=bit k (LSB_FIRST=1) or bit DATA_WIDTH-1-k (LSB_FIRST=0).
REQ-020 slave_tx_done=1 only during the cycle carrying bit k=DATA_WIDTH-1.
REQ-021 At the edge ending the last bit: if fifo_level>0 and master_ready=1, load the next word and stay in SHIFT (no gap cycle); else go to IDLE.
REQ-022 In IDLE: tx_valid=0, tx_data=0, slave_tx_done=0.
REQ-023 Minimum latency: word pushed at edge E into an empty FIFO, FSM idle, master_ready=1 -> load at edge E+1, bit 0 on tx_data in the cycle after E+1.
REQ-024 master_ready is sampled only at frame start; deassertion mid-frame does not stall or abort the frame.
REQ-025 Simultaneous push and pop: fifo_level unchanged; the pushed word becomes the newest entry.
REQ-026 Push into an empty FIFO is not visible to the FSM until the following edge (no bypass).
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; words leave in strict push order.
REQ-028 The bit counter has width $clog2(DATA_WIDTH) and never exceeds DATA_WIDTH-1.

Reset
REQ-029 reset=0 immediately forces: FIFO empty (pointers 0, fifo_level 0), state IDLE, tx_data 0, tx_valid 0, slave_tx_done 0, and therefore slave_ready 1.
REQ-030 Reset mid-frame discards the frame in flight and all buffered words; no bits are emitted after release until a new word is pushed.
REQ-031 Unreachable FSM encodings recover to IDLE on the next edge with outputs at reset values.

Structure
REQ-032 Package slave_tx_pkg holds the FSM state type (IDLE, SHIFT) and the default parameter constants.
REQ-033 Buffering is a sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH; push, pop, full, empty, level); the serializer FSM and shift register live in slave_tx_serializer.

Verification
REQ-034 DATA_WIDTH=8, LSB_FIRST=1, push 0xA5 with master_ready=1 -> tx_data 1,0,1,0,0,1,0,1 over 8 cycles with tx_valid=1; slave_tx_done only on the 8th cycle.
REQ-035 Push 0x3C then 0xC3, master_ready held 1 -> 16 consecutive tx_valid cycles with no gap: 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1; two done pulses.
REQ-036 master_ready=0, push 0x11,0x22,0x33,0x44 -> fifo_level 4, slave_ready 0; 5th word 0x55 is not stored; raise master_ready -> exactly 4 frames, in order.
REQ-037 LSB_FIRST=0, push 0x01 -> tx_data 0,0,0,0,0,0,0,1; done with the final 1.
REQ-038 Drive reset=0 during bit 3 of 0xFF with 2 words queued -> tx_valid, tx_data, done go to 0 at once, fifo_level 0; after release no tx_valid until a new push.
REQ-039 Drop master_ready during bit 2 of 0x0F -> frame completes all 8 bits; next queued word is not started until master_ready returns to 1.
